nn_result_tx: RTL and testbench
===============================

# nn_result_tx

Transmit-side counterpart to the neural-network byte receiver path. Captures each 24-bit accumulator result on its one-cycle trigger pulse and returns it to the host as a five-byte UART 8N1 frame: header, three data bytes MSB first, XOR checksum. Sits between the neural-network core (`dataOut`/`trigOut`) and the board TX pin. A one-deep pending buffer absorbs a result that arrives while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `trigIn`  in  1: one-cycle strobe; `dataIn` is valid in the same cycle.
- `dataIn`  in  24: result word to transmit.
- `txOut`  out  1: UART serial line; idles high.
- `busy`  out  1: high while a frame is loading, sending or completing.
- `frameDone`  out  1: one-cycle pulse after the last stop bit of a frame.
- `overrun`  out  1: sticky flag; set when a trigger is dropped; cleared only by `rst`.

## Operation
- **Frame format:**
  - Byte 0 is 0xA5.
  - Bytes 1–3 are `dataIn[23:16]`, `[15:8]`, `[7:0]`.
  - Byte 4 is the checksum, XOR of bytes 1–3. The header is excluded from the checksum.
- **Byte format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` cycles.
- **Controller FSM states:** IDLE, LOAD, SEND, DONE.
  - IDLE: when `trigIn`=1, latch `dataIn` into the frame register and go to LOAD.
  - LOAD: one cycle. Compute the checksum, reset the byte index to 0, and issue byte 0 to the serializer. Go to SEND.
  - SEND: whenever the serializer requests the next byte, issue byte[index+1]. After byte 4's stop bit completes, go to DONE.
  - DONE: one cycle with `frameDone`=1. If the pending buffer is full, move it into the frame register and go to LOAD. Otherwise go to IDLE.
- **Pending buffer:**
  - `trigIn`=1 in any state other than IDLE, with the buffer empty: store `dataIn` and mark the buffer full.
  - `trigIn`=1 in any state other than IDLE, with the buffer already full: drop the new word, keep the old one, and set `overrun`.
  - `trigIn`=1 in the DONE cycle counts as "not IDLE". The word is buffered, or dropped if the buffer is full.
- **Reset:** `rst` has priority over every other input. Reset values:
  - `txOut`=1, `busy`=0, `frameDone`=0, `overrun`=0.
  - Pending buffer empty, FSM in IDLE, serializer counters at 0.
  - Reset in mid-frame aborts the frame; `txOut` is high in the cycle after the reset edge. A `trigIn` asserted together with `rst` is ignored.
- **Width rules:**
  - The bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps at `CLKS_PER_BIT-1`.
  - The bit index counts 0–9. The byte index counts 0–4.

## Timing
- Let `trigIn` be sampled high at edge E0 while the FSM is in IDLE.
  - LOAD occupies cycle 1.
  - The start bit of the header drives `txOut` low from cycle 2.
- Bytes are sent back-to-back with no idle gap. The next start bit begins in the cycle after the previous stop bit's last cycle.
- Frame length on the line is exactly 50·`CLKS_PER_BIT` cycles, spanning cycles 2 to 1+50·`CLKS_PER_BIT`.
- `frameDone` is high in cycle 2+50·`CLKS_PER_BIT`.
- `busy` is high from cycle 1 through the `frameDone` cycle inclusive.
- Pending-buffer chaining: LOAD of the next frame follows DONE immediately. The line then idles high for exactly 2 cycles between frames (DONE and LOAD).
- A `trigIn` in IDLE is accepted in the same cycle; maximum acceptance latency is zero.

## Structure
- **Package `nn_tx_pkg`:**
  - `HEADER_BYTE` = 8'hA5 and `FRAME_BYTES` = 5.
  - One-hot state encoding constants for the controller.
  - Bit-frame constants: START = 0, STOP = 1, BITS_PER_BYTE = 10.
- **Sub-module `uart_tx_byte`:**
  - Parameter `CLKS_PER_BIT`.
  - Ports: `clk`, `rst`, `byteValid`, `byteData[7:0]`, `byteReady`, `txOut`.
  - Contains a one-deep holding register, so the controller can hand over the next byte during the current byte and sending stays gapless.
  - `byteReady` is high whenever the holding register is empty.
- The top level holds the controller FSM, the frame register, the checksum, the pending buffer and the overrun flag.

## Test plan
- **Basic frame**, `CLKS_PER_BIT`=4: pulse `trigIn` with 0x123456.
  - Decoded bytes are A5 12 34 56 70.
  - `txOut` first goes low 2 cycles after the trigger edge.
  - `frameDone` fires exactly 202 cycles after the trigger edge, and `busy` deasserts in the following cycle.
- **Edge values:** 0x000000 yields checksum 00; 0xFFFFFF yields checksum FF.
  - Every stop bit is high for exactly 4 cycles.
  - No gap appears between bytes.
- **Pending chaining:** trigger 0xABCDEF, then trigger 0x010203 at cycle 50.
  - The second frame A5 01 02 03 00 starts with exactly 2 high idle cycles after the first frame.
  - `overrun` stays 0.
- **Overrun:** three triggers within one frame (0x111111, 0x222222, 0x333333).
  - Only the 0x111111 and 0x222222 frames are sent.
  - `overrun` becomes 1 in the cycle after the third trigger and stays high until `rst`.
- **Reset mid-frame:** assert `rst` during the second data byte.
  - In the next cycle `txOut`=1, `busy`=0 and `overrun`=0.
  - No `frameDone` occurs.
  - A later trigger with 0x00FF00 sends a clean frame A5 00 FF 00 FF.
- **Trigger in DONE:** assert `trigIn` exactly in the `frameDone` cycle.
  - The word is buffered and transmitted as the next frame, not lost.

Source files
------------

// File: rtl/nn_tx_pkg.sv
// Shared constants, controller state encoding and frame helpers for the result transmitter.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package nn_tx_pkg;

   localparam logic [7:0] HEADER_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES   = 5;

   // Line levels of the framing bits and the number of line bits per byte
   localparam logic       START         = 1'b0;
   localparam logic       STOP          = 1'b1;
   localparam int         BITS_PER_BYTE = 10;

   // One-hot controller states
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_LOAD = 4'b0010,
      ST_SEND = 4'b0100,
      ST_DONE = 4'b1000
   } state_t;

   // Checksum covers the three data bytes only, never the header
   function automatic logic [7:0] frame_checksum(input logic [23:0] word);
      return word[23:16] ^ word[15:8] ^ word[7:0];
   endfunction

   // Byte at position idx of the five-byte frame
   function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                             input logic [23:0] word,
                                             input logic [7:0]  csum);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HEADER_BYTE;
         3'd1:    b = word[23:16];
         3'd2:    b = word[15:8];
         3'd3:    b = word[7:0];
         3'd4:    b = csum;
         default: b = HEADER_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer with a one-deep holding register for gapless back-to-back bytes.
// Latency: a byte accepted while the line is idle drives its start bit in the next cycle.
// Backpressure: byteReady is high whenever the holding register is empty.
module uart_tx_byte
   import nn_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byteValid,
   input  logic [7:0] byteData,
   output logic       byteReady,
   output logic       txOut
);

   localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        BIT_MAX = 4'(BITS_PER_BYTE - 1);

   logic             hold_vld_q, hold_vld_d;
   logic [7:0]       hold_dat_q, hold_dat_d;
   logic             active_q,   active_d;
   logic [9:0]       shift_q,    shift_d;
   logic [3:0]       bit_idx_q,  bit_idx_d;
   logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
   logic             tx_q,       tx_d;

   logic             accept;
   logic             bit_end;
   logic             last_end;
   logic             can_load;

   assign byteReady = !hold_vld_q;
   assign txOut     = tx_q;

   // Next-state of holding register, shifter and bit timing
   always_comb begin
      hold_vld_d = hold_vld_q;
      hold_dat_d = hold_dat_q;
      active_d   = active_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      clk_cnt_d  = clk_cnt_q;
      tx_d       = tx_q;

      accept   = byteValid && !hold_vld_q;
      bit_end  = active_q && (clk_cnt_q == CNT_MAX);
      last_end = bit_end && (bit_idx_q == BIT_MAX);
      // The shifter takes a new byte when idle, or on the last cycle of a stop bit
      can_load = !active_q || last_end;

      if (accept) begin
         hold_vld_d = 1'b1;
         hold_dat_d = byteData;
      end

      if (can_load && (hold_vld_q || accept)) begin
         // A byte offered to an idle shifter bypasses the holding register
         shift_d    = {STOP, (hold_vld_q ? hold_dat_q : byteData), START};
         hold_vld_d = 1'b0;
         active_d   = 1'b1;
         bit_idx_d  = '0;
         clk_cnt_d  = '0;
         tx_d       = START;
      end else if (last_end) begin
         active_d  = 1'b0;
         bit_idx_d = '0;
         clk_cnt_d = '0;
         tx_d      = STOP;
      end else if (bit_end) begin
         bit_idx_d = bit_idx_q + 4'd1;
         clk_cnt_d = '0;
         tx_d      = shift_q[bit_idx_q + 4'd1];
      end else if (active_q) begin
         clk_cnt_d = clk_cnt_q + 1'b1;
      end
   end

   // State registers; reset leaves the line idle high
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld_q <= 1'b0;
         hold_dat_q <= '0;
         active_q   <= 1'b0;
         shift_q    <= '1;
         bit_idx_q  <= '0;
         clk_cnt_q  <= '0;
         tx_q       <= STOP;
      end else begin
         hold_vld_q <= hold_vld_d;
         hold_dat_q <= hold_dat_d;
         active_q   <= active_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         clk_cnt_q  <= clk_cnt_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: rtl/nn_result_tx.sv
// Frames each 24-bit result as A5, three data bytes MSB first, XOR checksum, sent as UART 8N1.
// Latency: LOAD in the cycle after the trigger edge, start bit one cycle later; 50*CLKS_PER_BIT line cycles.
// Backpressure: none upstream; one-deep pending buffer, further triggers are dropped and flagged by overrun.
module nn_result_tx
   import nn_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigIn,
   input  logic [23:0] dataIn,
   output logic        txOut,
   output logic        busy,
   output logic        frameDone,
   output logic        overrun
);

   localparam int               FRM_CYCLES = FRAME_BYTES * BITS_PER_BYTE * CLKS_PER_BIT;
   localparam int               FCNT_W     = $clog2(FRM_CYCLES);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRM_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX   = 3'(FRAME_BYTES - 1);

   state_t            state_q, state_d;
   logic [23:0]       frame_q, frame_d;
   logic [7:0]        csum_q, csum_d;
   logic [2:0]        byte_idx_q, byte_idx_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              pend_vld_q, pend_vld_d;
   logic [23:0]       pend_dat_q, pend_dat_d;
   logic              overrun_q, overrun_d;

   logic              byte_vld;
   logic [7:0]        byte_dat;
   logic              byte_rdy;
   logic              byte_fire;
   logic              trig_to_buffer;

   assign overrun   = overrun_q;
   assign byte_fire = byte_vld && byte_rdy;

   // Triggers outside IDLE go to the pending buffer; in DONE with an empty buffer the
   // word is chained straight into the frame register instead, which is the same outcome
   assign trig_to_buffer = trigIn &&
                           ((state_q == ST_LOAD) || (state_q == ST_SEND) ||
                            ((state_q == ST_DONE) && pend_vld_q));

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .byteValid (byte_vld),
      .byteData  (byte_dat),
      .byteReady (byte_rdy),
      .txOut     (txOut)
   );

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Controller next state; frame end is timed by counting line cycles since the
   // serializer sends the five bytes without gaps
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (trigIn) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: if (fcnt_q == FCNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = (pend_vld_q || trigIn) ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller outputs and byte hand-off to the serializer
   always_comb begin
      busy      = (state_q != ST_IDLE);
      frameDone = (state_q == ST_DONE);
      byte_vld  = 1'b0;
      byte_dat  = HEADER_BYTE;
      unique case (state_q)
         ST_LOAD: byte_vld = 1'b1;
         ST_SEND: begin
            if (byte_idx_q < LAST_IDX) begin
               byte_vld = 1'b1;
               byte_dat = frame_byte(byte_idx_q + 3'd1, frame_q, csum_q);
            end
         end
         default: ;
      endcase
   end

   // Frame register, checksum, byte index, frame timer, pending buffer, overrun
   always_comb begin
      frame_d    = frame_q;
      csum_d     = csum_q;
      byte_idx_d = byte_idx_q;
      fcnt_d     = fcnt_q;
      pend_vld_d = pend_vld_q;
      pend_dat_d = pend_dat_q;
      overrun_d  = overrun_q;

      unique case (state_q)
         ST_IDLE: if (trigIn) frame_d = dataIn;
         ST_LOAD: begin
            csum_d     = frame_checksum(frame_q);
            byte_idx_d = '0;
            fcnt_d     = '0;
         end
         ST_SEND: begin
            fcnt_d = fcnt_q + 1'b1;
            if (byte_fire) byte_idx_d = byte_idx_q + 3'd1;
         end
         ST_DONE: begin
            if (pend_vld_q) begin
               frame_d    = pend_dat_q;
               pend_vld_d = 1'b0;
            end else if (trigIn) begin
               frame_d = dataIn;
            end
         end
         default: ;
      endcase

      // A full buffer keeps its older word; the newcomer is dropped and flagged
      if (trig_to_buffer) begin
         if (pend_vld_q) begin
            overrun_d = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            pend_dat_d = dataIn;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q    <= '0;
         csum_q     <= '0;
         byte_idx_q <= '0;
         fcnt_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_dat_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         csum_q     <= csum_d;
         byte_idx_q <= byte_idx_d;
         fcnt_q     <= fcnt_d;
         pend_vld_q <= pend_vld_d;
         pend_dat_q <= pend_dat_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_nn_result_tx.sv
// Self-checking bench for nn_result_tx with CLKS_PER_BIT=4.
// Latency: line activity is logged every cycle and compared against frames built from the data words.
// Backpressure: not applicable.
module tb_nn_result_tx;

   localparam int CPB  = 4;
   localparam int FRM  = 50 * CPB;
   localparam int MAXC = 8192;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        trigIn  = 1'b0;
   logic [23:0] dataIn  = '0;
   logic        txOut;
   logic        busy;
   logic        frameDone;
   logic        overrun;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   logic tx_log   [MAXC];
   logic done_log [MAXC];
   logic busy_log [MAXC];
   logic ovr_log  [MAXC];

   nn_result_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .trigIn    (trigIn),
      .dataIn    (dataIn),
      .txOut     (txOut),
      .busy      (busy),
      .frameDone (frameDone),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log index n holds the outputs in the cycle after the n-th rising edge
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         tx_log[cyc]   = txOut;
         done_log[cyc] = frameDone;
         busy_log[cyc] = busy;
         ovr_log[cyc]  = overrun;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Pulse trigIn so that it is sampled by rising edge number t; returns that edge number
   task automatic trig_at(input int t, input logic [23:0] d, output int t_s);
      wait_until(t - 1);
      trigIn = 1'b1;
      dataIn = d;
      @(negedge clk);
      trigIn = 1'b0;
      t_s    = cyc;
   endtask

   // Reference frame: header, data MSB first, XOR of the data bytes
   function automatic logic [7:0] model_byte(input logic [23:0] d, input int i);
      logic [7:0] b [5];
      b[0] = 8'hA5;
      b[1] = d[23:16];
      b[2] = d[15:8];
      b[3] = d[7:0];
      b[4] = d[23:16] ^ d[15:8] ^ d[7:0];
      return b[i];
   endfunction

   // Frame triggered at edge t0: LOAD at index t0, line t0+1..t0+FRM, DONE at t0+1+FRM
   task automatic check_frame(input string tag, input int t0, input logic [23:0] d);
      int         s, mism, dn, bz;
      logic [7:0] got, exp_b;
      logic       eb;
      wait_until(t0 + FRM + 3);
      s    = t0 + 1;
      mism = 0;
      for (int i = 0; i < 5; i++) begin
         exp_b = model_byte(d, i);
         for (int j = 0; j < 10; j++) begin
            eb = (j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : exp_b[j-1]);
            for (int k = 0; k < CPB; k++)
               if (tx_log[s + (i*10 + j)*CPB + k] !== eb) mism++;
         end
      end
      chk({tag, ".wave_mismatches"}, 32'(mism), 32'd0);
      for (int i = 0; i < 5; i++) begin
         got = '0;
         for (int j = 0; j < 8; j++) got[j] = tx_log[s + (i*10 + j + 1)*CPB + CPB/2];
         chk($sformatf("%s.byte%0d", tag, i), 32'(got), 32'(model_byte(d, i)));
      end
      chk({tag, ".idle_in_load"}, 32'(tx_log[t0]), 32'd1);
      chk({tag, ".idle_in_done"}, 32'(tx_log[t0 + 1 + FRM]), 32'd1);
      chk({tag, ".frame_done"}, 32'(done_log[t0 + 1 + FRM]), 32'd1);
      dn = 0;
      bz = 0;
      for (int c = t0; c <= t0 + FRM; c++) if (done_log[c] !== 1'b0) dn++;
      for (int c = t0; c <= t0 + 1 + FRM; c++) if (busy_log[c] === 1'b1) bz++;
      chk({tag, ".early_done"}, 32'(dn), 32'd0);
      chk({tag, ".busy_cycles"}, 32'(bz), 32'(FRM + 2));
   endtask

   initial begin
      int          t0, t1, t3, tr, fl, cnt, k;
      logic [23:0] d1, d2;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset.txOut", 32'(txOut), 32'd1);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.frameDone", 32'(frameDone), 32'd0);
      chk("reset.overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame and its timing
      trig_at(cyc + 1, 24'h123456, t0);
      check_frame("basic", t0, 24'h123456);
      fl = -1;
      for (int c = t0 + FRM; c >= t0 - 1; c--) if (tx_log[c] === 1'b0) fl = c;
      chk("basic.first_low_cycle", 32'(fl - t0 + 1), 32'd2);
      chk("basic.busy_off", 32'(busy_log[t0 + 2 + FRM]), 32'd0);

      // Edge values
      trig_at(cyc + 2, 24'h000000, t0);
      check_frame("zeros", t0, 24'h000000);
      trig_at(cyc + 2, 24'hFFFFFF, t0);
      check_frame("ones", t0, 24'hFFFFFF);

      // Pending chaining
      trig_at(cyc + 3, 24'hABCDEF, t0);
      trig_at(t0 + 50, 24'h010203, t1);
      check_frame("chain.a", t0, 24'hABCDEF);
      check_frame("chain.b", t0 + 2 + FRM, 24'h010203);
      chk("chain.overrun", 32'(overrun), 32'd0);

      // Overrun: third trigger within one frame is dropped
      trig_at(cyc + 3, 24'h111111, t0);
      trig_at(t0 + 10, 24'h222222, t1);
      trig_at(t0 + 20, 24'h333333, t3);
      check_frame("ovr.a", t0, 24'h111111);
      check_frame("ovr.b", t0 + 2 + FRM, 24'h222222);
      chk("ovr.before", 32'(ovr_log[t3 - 1]), 32'd0);
      chk("ovr.after", 32'(ovr_log[t3]), 32'd1);
      t1 = t0 + 2 + FRM;
      wait_until(t1 + FRM + 62);
      cnt = 0;
      for (int c = t1 + 2 + FRM; c <= t1 + FRM + 61; c++)
         if (busy_log[c] !== 1'b0 || tx_log[c] !== 1'b1) cnt++;
      chk("ovr.no_third_frame", 32'(cnt), 32'd0);
      chk("ovr.sticky", 32'(overrun), 32'd1);

      // Reset during the second data byte, with a trigger in the reset cycle
      trig_at(cyc + 2, 24'h5A5A5A, t0);
      wait_until(t0 + 100);
      rst    = 1'b1;
      trigIn = 1'b1;
      dataIn = 24'($urandom);
      @(negedge clk);
      tr = cyc;
      chk("rst.txOut", 32'(txOut), 32'd1);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.overrun", 32'(overrun), 32'd0);
      rst    = 1'b0;
      trigIn = 1'b0;
      wait_until(tr + FRM + 20);
      cnt = 0;
      for (int c = t0; c <= tr + FRM + 19; c++) if (done_log[c] !== 1'b0) cnt++;
      chk("rst.no_frame_done", 32'(cnt), 32'd0);
      cnt = 0;
      for (int c = tr; c <= tr + FRM + 19; c++) if (tx_log[c] !== 1'b1) cnt++;
      chk("rst.line_quiet", 32'(cnt), 32'd0);
      trig_at(cyc + 1, 24'h00FF00, t0);
      check_frame("post_rst", t0, 24'h00FF00);

      // Trigger exactly in the frameDone cycle
      trig_at(cyc + 2, 24'hC0FFEE, t0);
      wait_until(t0 + 1 + FRM);
      chk("tdone.frameDone_at_trig", 32'(frameDone), 32'd1);
      trig_at(t0 + 2 + FRM, 24'h4D2E1F, t1);
      check_frame("tdone.a", t0, 24'hC0FFEE);
      check_frame("tdone.b", t0 + 2 + FRM, 24'h4D2E1F);

      // Random words, alternating single frames and chained pairs at random offsets
      for (int it = 0; it < 4; it++) begin
         d1 = 24'($urandom);
         d2 = 24'($urandom);
         trig_at(cyc + int'($urandom_range(1, 15)), d1, t0);
         if (it % 2 == 0) begin
            k = int'($urandom_range(1, FRM + 2));
            trig_at(t0 + k, d2, t1);
            check_frame($sformatf("rand%0d.a", it), t0, d1);
            check_frame($sformatf("rand%0d.b", it), t0 + 2 + FRM, d2);
         end else begin
            check_frame($sformatf("rand%0d", it), t0, d1);
         end
      end
      repeat (5) @(negedge clk);
      chk("final.busy", 32'(busy), 32'd0);
      chk("final.overrun", 32'(overrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
